// File: rtl/sensors_pkg.sv
// Shared types and sizes for the baggage-drop height sensor acquisition path.
package sensors_pkg;

    localparam int unsigned NUM_SENSORS = 4;
    localparam int unsigned SENS_W      = 8;
    localparam int unsigned IDX_W       = $clog2(NUM_SENSORS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    // One complete frame: a byte per sensor plus its timeout flag.
    typedef struct packed {
        logic [NUM_SENSORS-1:0]             err;
        logic [NUM_SENSORS-1:0][SENS_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/sensors_if.sv
// Shared four-phase req/ack bus between the acquisition block and the sensors.
interface sensors_if;
    import sensors_pkg::*;

    logic [IDX_W-1:0]  sens_sel;
    logic              sens_req;
    logic              sens_ack;
    logic [SENS_W-1:0] sens_data;

    modport master (
        output sens_sel,
        output sens_req,
        input  sens_ack,
        input  sens_data
    );

    modport slave (
        input  sens_sel,
        input  sens_req,
        output sens_ack,
        output sens_data
    );

endinterface

// File: rtl/sensors_timeout_cnt.sv
// Handshake phase timer: flags expiry once a phase has lasted TIMEOUT cycles.
module sensors_timeout_cnt #(
    parameter  int unsigned TIMEOUT = 16,
    localparam int unsigned CNT_W   = $clog2(TIMEOUT) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 2);

    logic [CNT_W-1:0] cnt_q;

    // expired is registered one count early so it is high during the TIMEOUT-th cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else if (clr || !en) begin
            cnt_q   <= '0;
            expired <= 1'b0;
        end else begin
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cnt_q == CNT_PRE) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensors_acquire.sv
// Polls four height sensors over a shared req/ack bus and publishes them as one
// atomically updated frame; an unresponsive sensor reads 0 with its err bit set.
module sensors_acquire
    import sensors_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   continuous,
    sensors_if.master              bus,
    output logic [SENS_W-1:0]      sensor1,
    output logic [SENS_W-1:0]      sensor2,
    output logic [SENS_W-1:0]      sensor3,
    output logic [SENS_W-1:0]      sensor4,
    output logic [NUM_SENSORS-1:0] sensor_err,
    output logic                   frame_valid,
    output logic                   busy
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    frame_t           shadow_q, shadow_d;
    frame_t           frame_q;
    logic             publish_c;
    logic             last_c;
    logic             clr_c;
    logic             en_c;
    logic             expired;

    assign last_c = (idx_q == IDX_W'(NUM_SENSORS - 1));
    assign clr_c  = (state_d != state_q);
    assign en_c   = (state_q != IDLE);

    sensors_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_c),
        .en      (en_c),
        .expired (expired)
    );

    // Next state, poll index and shadow capture.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        publish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start || continuous) begin
                    state_d = REQ;
                    idx_d   = '0;
                end
            end
            REQ: begin
                // An ack on the expiry cycle still counts as a response.
                if (bus.sens_ack) begin
                    shadow_d.data[idx_q] = bus.sens_data;
                    shadow_d.err[idx_q]  = 1'b0;
                    state_d              = REL;
                end else if (expired) begin
                    shadow_d.data[idx_q] = '0;
                    shadow_d.err[idx_q]  = 1'b1;
                    state_d              = REL;
                end
            end
            REL: begin
                if (!bus.sens_ack || expired) begin
                    if (bus.sens_ack) begin
                        shadow_d.data[idx_q] = '0;
                        shadow_d.err[idx_q]  = 1'b1;
                    end
                    if (last_c) begin
                        state_d   = IDLE;
                        publish_c = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
        end
    end

    // Registered bus drive and frame outputs; the frame copies the merged shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sens_req <= 1'b0;
            bus.sens_sel <= '0;
            busy         <= 1'b0;
            frame_valid  <= 1'b0;
            frame_q      <= '0;
        end else begin
            bus.sens_req <= (state_d == REQ);
            bus.sens_sel <= idx_d;
            busy         <= (state_d != IDLE);
            frame_valid  <= publish_c;
            if (publish_c) begin
                frame_q <= shadow_d;
            end
        end
    end

    assign sensor1    = frame_q.data[0];
    assign sensor2    = frame_q.data[1];
    assign sensor3    = frame_q.data[2];
    assign sensor4    = frame_q.data[3];
    assign sensor_err = frame_q.err;

endmodule

// File: tb/tb_sensors_acquire.sv
// Randomized bench for sensors_acquire: a configurable sensor responder plus a
// frame-level model predicting each frame's contents and completion cycle.
module tb_sensors_acquire;
    import sensors_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       continuous = 1'b0;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic [3:0] sensor_err;
    logic       frame_valid;
    logic       busy;

    sensors_if bus ();

    sensors_acquire #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .bus         (bus.master),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .sensor3     (sensor3),
        .sensor4     (sensor4),
        .sensor_err  (sensor_err),
        .frame_valid (frame_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: mode 0 acks after cfg_dly cycles of req, 1 never acks, 2 holds ack high.
    int         cfg_mode [NUM_SENSORS];
    int         cfg_dly  [NUM_SENSORS];
    logic [7:0] cfg_data [NUM_SENSORS];
    int         req_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            req_cnt <= 0;
        else if (bus.sens_req) req_cnt <= req_cnt + 1;
        else                   req_cnt <= 0;
    end

    always_comb begin
        bus.sens_data = cfg_data[bus.sens_sel];
        case (cfg_mode[bus.sens_sel])
            1:       bus.sens_ack = 1'b0;
            2:       bus.sens_ack = 1'b1;
            default: bus.sens_ack = bus.sens_req && (req_cnt >= cfg_dly[bus.sens_sel]);
        endcase
    end

    typedef struct {
        int          s;
        int          fv;
        logic [31:0] data;
        logic [3:0]  err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] held_data = '0;
    logic [3:0]  held_err = '0;
    bit          chk_en = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Frame model: a responding sensor costs delay+2 cycles, any failure TIMEOUT+1.
    task automatic push_frame(input int s, output int fv);
        exp_t e;
        int   t;
        t      = s;
        e.data = '0;
        e.err  = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (cfg_mode[i] == 0 && cfg_dly[i] <= TIMEOUT - 1) begin
                e.data[8*i +: 8] = cfg_data[i];
                t += cfg_dly[i] + 2;
            end else begin
                e.err[i] = 1'b1;
                t += TIMEOUT + 1;
            end
        end
        e.s  = s;
        e.fv = t;
        q.push_back(e);
        fv = t;
    endtask

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit fv_exp;
            bit busy_exp;
            fv_exp   = (q.size() > 0) && (q[0].fv == cyc);
            busy_exp = (q.size() > 0) && (cyc >= q[0].s) && (cyc < q[0].fv);
            if (fv_exp) begin
                held_data = q[0].data;
                held_err  = q[0].err;
                void'(q.pop_front());
            end
            check("frame_valid", 64'(frame_valid), 64'(fv_exp));
            check("busy", 64'(busy), 64'(busy_exp));
            check("sensors", 64'({sensor4, sensor3, sensor2, sensor1}), 64'(held_data));
            check("sensor_err", 64'(sensor_err), 64'(held_err));
            if (!busy_exp) check("sens_req_idle", 64'(bus.sens_req), 64'd0);
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_frame(output int s, output int fv);
        start = 1'b1;
        s     = cyc + 1;
        push_frame(s, fv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_cfg(input int maxd);
        for (int i = 0; i < NUM_SENSORS; i++) begin
            cfg_mode[i] = 0;
            cfg_dly[i]  = int'($urandom_range(0, maxd));
            cfg_data[i] = 8'($urandom);
        end
    endtask

    task automatic set_fixed();
        for (int i = 0; i < NUM_SENSORS; i++) begin
            cfg_mode[i] = 0;
            cfg_dly[i]  = 0;
            cfg_data[i] = 8'(8'h40 + 2 * i);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s, fv, fv_prev;
        set_fixed();
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_sensors", 64'({sensor4, sensor3, sensor2, sensor1}), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        // Combinational ack: frame 8 cycles after start is sampled.
        start_frame(s, fv);
        wait_until(s + 8);
        check("t1_fv", 64'(frame_valid), 64'd1);
        check("t1_data", 64'({sensor4, sensor3, sensor2, sensor1}), 64'h46444240);
        check("t1_err", 64'(sensor_err), 64'd0);
        wait_until(fv);

        // Sensor 3 silent.
        cfg_mode[2] = 1;
        start_frame(s, fv);
        wait_until(s + 23);
        check("t2_fv", 64'(frame_valid), 64'd1);
        check("t2_data", 64'({sensor4, sensor3, sensor2, sensor1}), 64'h46004240);
        check("t2_err", 64'(sensor_err), 64'b0100);
        wait_until(fv);

        // Sensor 2 holds ack high.
        set_fixed();
        cfg_mode[1] = 2;
        start_frame(s, fv);
        wait_until(s + 23);
        check("t3_fv", 64'(frame_valid), 64'd1);
        check("t3_data", 64'({sensor4, sensor3, sensor2, sensor1}), 64'h46440040);
        check("t3_err", 64'(sensor_err), 64'b0010);
        wait_until(fv);

        // Continuous frames with stray start pulses while busy.
        set_cfg(0);
        continuous = 1'b1;
        push_frame(cyc + 1, fv);
        for (int k = 0; k < 4; k++) begin
            wait_until(fv - 5);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_until(fv);
            if (k > 0) check("t4_spacing", 64'(fv - fv_prev), 64'd9);
            check("t4_fv", 64'(frame_valid), 64'd1);
            fv_prev = fv;
            if (k == 3) begin
                continuous = 1'b0;
            end else begin
                set_cfg(0);
                push_frame(fv + 1, fv);
            end
        end
        repeat (3) @(negedge clk);

        // Reset while polling sensor 3.
        for (int i = 0; i < NUM_SENSORS; i++) cfg_dly[i] = 3;
        start_frame(s, fv);
        wait_until(s + 11);
        check("t5_req_before", 64'(bus.sens_req), 64'd1);
        check("t5_sel_before", 64'(bus.sens_sel), 64'd2);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("t5_req", 64'(bus.sens_req), 64'd0);
        check("t5_sel", 64'(bus.sens_sel), 64'd0);
        check("t5_outs", 64'({sensor4, sensor3, sensor2, sensor1}), 64'd0);
        check("t5_err", 64'(sensor_err), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        q.delete();
        held_data = '0;
        held_err  = '0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_idle", 64'(busy), 64'd0);
        set_cfg(TIMEOUT - 2);
        start_frame(s, fv);
        wait_until(fv);

        // Boundary: ack on the expiry cycle wins; one cycle later is a timeout.
        cfg_dly[0] = TIMEOUT - 1;
        cfg_dly[1] = TIMEOUT;
        cfg_dly[2] = 0;
        cfg_dly[3] = TIMEOUT - 2;
        start_frame(s, fv);
        wait_until(s + 52);
        check("t6_bnd_fv", 64'(frame_valid), 64'd1);
        check("t6_bnd_err", 64'(sensor_err), 64'b0010);
        check("t6_bnd_s2", 64'(sensor2), 64'd0);
        wait_until(fv);

        // Random ack delays with one zero byte per frame.
        for (int f = 0; f < 20; f++) begin
            int z;
            set_cfg(TIMEOUT - 2);
            z = int'($urandom_range(0, NUM_SENSORS - 1));
            cfg_data[z] = 8'h00;
            start_frame(s, fv);
            wait_until(fv);
            check("t6_err", 64'(sensor_err), 64'd0);
            repeat (int'($urandom_range(0, 2))) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
